// File: rtl/pc_sequencer.sv
// ----------------------------------------------------------------------------
// pc_sequencer
//
// Next-PC controller for the 5-stage 16-bit pipeline. It sits beside the PC
// register and decides, every cycle, which address the PC register loads
// (new_pc) and whether it loads at all (pc_write). It arbitrates the redirect
// sources:
//   - EX branch
//   - ID jump / iret
//   - interrupt
//   - halt
//   - hazard stall
//   - instruction-memory wait
// It also drives the pipeline flush lines and keeps the interrupt bookkeeping
// (saved return address, interrupt enable).
//
// All decisions are combinational from the current state and the inputs, so
// the PC register updates at the very edge the decision is made. The only
// storage is the FSM state, a pending redirect target, epc and irq_en.
//
// Ports:
//   clk          in   1   system clock, rising edge
//   reset        in   1   synchronous, active-low reset
//   pc_cur       in  16   current PC (address being fetched this cycle)
//   imem_ready   in   1   instruction memory returns the word for pc_cur
//   stall_req    in   1   load-use stall from the hazard unit
//   br_taken     in   1   branch resolved taken in EX
//   br_target    in  16   branch target
//   jmp          in   1   unconditional jump decoded in ID
//   jmp_target   in  16   jump target
//   iret         in   1   return-from-interrupt decoded in ID
//   halt_req     in   1   HLT decoded in ID
//   irq          in   1   level interrupt request
//   pc_write     out  1   PC register load enable
//   new_pc       out 16   next PC value
//   imem_req     out  1   fetch request
//   flush_if_id  out  1   load a bubble into IF/ID at this edge
//   flush_id_ex  out  1   load a bubble into ID/EX at this edge
//   irq_ack      out  1   one-cycle pulse when the interrupt is taken
//   epc          out 16   saved return address (registered)
//   halted       out  1   high while in the HALT state
// ----------------------------------------------------------------------------
module pc_sequencer #(
  parameter logic [15:0] RESET_VECTOR = 16'h0000,
  parameter logic [15:0] IRQ_VECTOR   = 16'h0010,
  parameter logic [15:0] PC_STEP      = 16'h0001
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] pc_cur,
  input  logic        imem_ready,
  input  logic        stall_req,
  input  logic        br_taken,
  input  logic [15:0] br_target,
  input  logic        jmp,
  input  logic [15:0] jmp_target,
  input  logic        iret,
  input  logic        halt_req,
  input  logic        irq,
  output logic        pc_write,
  output logic [15:0] new_pc,
  output logic        imem_req,
  output logic        flush_if_id,
  output logic        flush_id_ex,
  output logic        irq_ack,
  output logic [15:0] epc,
  output logic        halted
);

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    PEND = 2'd1,
    HALT = 2'd2
  } state_t;

  // Registered state and next-state values.
  state_t      state_q,       state_d;
  logic [15:0] pend_target_q, pend_target_d;
  logic [15:0] epc_q,         epc_d;
  logic        irq_en_q,      irq_en_d;

  // RUN-state redirect decision (valid only in RUN).
  logic        redirect;
  logic [15:0] target;

  // Sequential fall-through address; 16-bit add wraps FFFF -> 0000.
  logic [15:0] pc_seq;
  assign pc_seq = pc_cur + PC_STEP;

  // The interrupt is only eligible when enabled; shared by RUN and HALT.
  logic irq_take;
  assign irq_take = irq && irq_en_q;

  assign epc = epc_q;

  // --------------------------------------------------------------------------
  // Output and next-state decision
  // --------------------------------------------------------------------------
  always_comb begin
    // Defaults: sequential address, nothing asserted, state held.
    pc_write      = 1'b0;
    new_pc        = pc_seq;
    imem_req      = 1'b0;
    flush_if_id   = 1'b0;
    flush_id_ex   = 1'b0;
    irq_ack       = 1'b0;
    halted        = 1'b0;
    redirect      = 1'b0;
    target        = pc_seq;
    state_d       = state_q;
    pend_target_d = pend_target_q;
    epc_d         = epc_q;
    irq_en_d      = irq_en_q;

    if (!reset) begin
      // Outputs are pinned during reset; the registers are reinitialised by
      // the sequential block, so the next-state values are don't-care here.
      new_pc = RESET_VECTOR;
    end else begin
      case (state_q)
        RUN: begin
          imem_req = 1'b1;
          // Priority chain, highest first. A stall only blocks the ID-stage
          // sources; a taken branch in EX still wins over it.
          if (br_taken) begin
            redirect    = 1'b1;
            target      = br_target;
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
          end else if (stall_req) begin
            // Hold PC; the ID instruction re-presents next cycle.
            pc_write = 1'b0;
          end else if (jmp) begin
            redirect    = 1'b1;
            target      = jmp_target;
            flush_if_id = 1'b1;
          end else if (iret) begin
            redirect    = 1'b1;
            target      = epc_q;
            flush_if_id = 1'b1;
            irq_en_d    = 1'b1;
          end else if (halt_req) begin
            // The fetch behind HLT is squashed and the PC frozen.
            flush_if_id = 1'b1;
            pc_write    = 1'b0;
            state_d     = HALT;
          end else if (irq_take) begin
            redirect    = 1'b1;
            target      = IRQ_VECTOR;
            flush_if_id = 1'b1;
            irq_ack     = 1'b1;
            epc_d       = pc_cur;
            irq_en_d    = 1'b0;
          end else begin
            pc_write = imem_ready;
          end

          // A redirect cannot land while the memory is still busy with the
          // current fetch, so the target is parked until imem_ready. The
          // flushes and irq_ack above still fire this cycle.
          if (redirect) begin
            if (imem_ready) begin
              pc_write = 1'b1;
              new_pc   = target;
            end else begin
              pc_write      = 1'b0;
              pend_target_d = target;
              state_d       = PEND;
            end
          end
        end

        PEND: begin
          imem_req    = 1'b1;
          // Whatever arrives for the in-flight fetch is wrong-path.
          flush_if_id = 1'b1;
          // Only a later branch can supersede the parked target; ID-stage
          // requests come from squashed instructions and are ignored.
          if (br_taken) begin
            pend_target_d = br_target;
            flush_id_ex   = 1'b1;
          end
          if (imem_ready) begin
            pc_write = 1'b1;
            new_pc   = br_taken ? br_target : pend_target_q;
            state_d  = RUN;
          end
        end

        HALT: begin
          halted = 1'b1;
          // Only an enabled interrupt wakes the core; otherwise reset is the
          // sole exit.
          if (irq_take) begin
            new_pc   = IRQ_VECTOR;
            pc_write = 1'b1;
            irq_ack  = 1'b1;
            epc_d    = pc_cur;
            irq_en_d = 1'b0;
            state_d  = RUN;
          end
        end

        default: begin
          // Unreachable encoding: recover to RUN.
          state_d = RUN;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      // Any pending redirect or halt is discarded.
      state_q       <= RUN;
      pend_target_q <= 16'h0000;
      epc_q         <= 16'h0000;
      irq_en_q      <= 1'b1;
    end else begin
      state_q       <= state_d;
      pend_target_q <= pend_target_d;
      epc_q         <= epc_d;
      irq_en_q      <= irq_en_d;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  logic        clk;
  logic        reset;
  logic [15:0] pc_cur;
  logic        imem_ready;
  logic        stall_req;
  logic        br_taken;
  logic [15:0] br_target;
  logic        jmp;
  logic [15:0] jmp_target;
  logic        iret;
  logic        halt_req;
  logic        irq;
  logic        pc_write;
  logic [15:0] new_pc;
  logic        imem_req;
  logic        flush_if_id;
  logic        flush_id_ex;
  logic        irq_ack;
  logic [15:0] epc;
  logic        halted;

  int checks = 0;
  int errors = 0;

  pc_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .pc_cur      (pc_cur),
    .imem_ready  (imem_ready),
    .stall_req   (stall_req),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .jmp         (jmp),
    .jmp_target  (jmp_target),
    .iret        (iret),
    .halt_req    (halt_req),
    .irq         (irq),
    .pc_write    (pc_write),
    .new_pc      (new_pc),
    .imem_req    (imem_req),
    .flush_if_id (flush_if_id),
    .flush_id_ex (flush_id_ex),
    .irq_ack     (irq_ack),
    .epc         (epc),
    .halted      (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Packed view of the control outputs:
  // {pc_write, imem_req, flush_if_id, flush_id_ex, irq_ack, halted}
  function automatic logic [15:0] ctl();
    return {10'd0, pc_write, imem_req, flush_if_id, flush_id_ex, irq_ack, halted};
  endfunction

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    stall_req  = 1'b0;
    br_taken   = 1'b0;
    br_target  = 16'h0000;
    jmp        = 1'b0;
    jmp_target = 16'h0000;
    iret       = 1'b0;
    halt_req   = 1'b0;
    irq        = 1'b0;
    imem_ready = 1'b1;
  endtask

  initial begin
    quiet();
    reset  = 1'b0;
    pc_cur = 16'h0000;

    // ---- Reset, then sequential fetch ----
    settle();
    chk("rst_newpc_c1", new_pc, 16'h0000);
    chk("rst_ctl_c1", ctl(), 16'h0000);
    $display("step reset cycle 1: new_pc=%h ctl=%b", new_pc, ctl());
    adv();
    settle();
    chk("rst_newpc_c2", new_pc, 16'h0000);
    chk("rst_ctl_c2", ctl(), 16'h0000);
    $display("step reset cycle 2: new_pc=%h ctl=%b", new_pc, ctl());
    adv();
    reset = 1'b1;
    settle();
    chk("seq_newpc", new_pc, 16'h0001);
    chk("seq_ctl", ctl(), 16'b110000);
    chk("rst_epc", epc, 16'h0000);
    $display("step seq: new_pc=%h ctl=%b", new_pc, ctl());

    pc_cur = 16'hFFFF;
    settle();
    chk("wrap_newpc", new_pc, 16'h0000);
    chk("wrap_ctl", ctl(), 16'b110000);
    $display("step wrap: new_pc=%h", new_pc);
    adv();

    // ---- Branch beats stall and jump ----
    pc_cur = 16'h0020; br_taken = 1'b1; br_target = 16'h0100;
    stall_req = 1'b1; jmp = 1'b1; jmp_target = 16'h0999;
    settle();
    chk("br_newpc", new_pc, 16'h0100);
    chk("br_ctl", ctl(), 16'b111100);
    $display("step branch: new_pc=%h ctl=%b", new_pc, ctl());
    adv();

    // Stall with a jump present: nothing moves, no flush.
    br_taken = 1'b0; pc_cur = 16'h0100;
    settle();
    chk("stall_ctl", ctl(), 16'b010000);
    $display("step stall: ctl=%b", ctl());
    adv();

    // ---- Redirect during memory wait ----
    quiet();
    pc_cur = 16'h0101; jmp = 1'b1; jmp_target = 16'h0040; imem_ready = 1'b0;
    settle();
    chk("jwait_ctl", ctl(), 16'b011000);
    $display("step jmp wait: ctl=%b", ctl());
    adv();
    jmp = 1'b0; br_taken = 1'b1; br_target = 16'h0080;
    settle();
    chk("pend_br_ctl", ctl(), 16'b011100);
    $display("step pend branch: ctl=%b", ctl());
    adv();
    br_taken = 1'b0; imem_ready = 1'b1;
    jmp = 1'b1; jmp_target = 16'h0777;  // ignored while pending
    settle();
    chk("pend_done_newpc", new_pc, 16'h0080);
    chk("pend_done_ctl", ctl(), 16'b111000);
    $display("step pend done: new_pc=%h ctl=%b", new_pc, ctl());
    adv();
    jmp = 1'b0; pc_cur = 16'h0080;
    settle();
    chk("after_pend_newpc", new_pc, 16'h0081);
    chk("after_pend_ctl", ctl(), 16'b110000);
    $display("step back in run: new_pc=%h ctl=%b", new_pc, ctl());
    adv();

    // ---- Interrupt entry / return ----
    pc_cur = 16'h0033; irq = 1'b1;
    settle();
    chk("irq_newpc", new_pc, 16'h0010);
    chk("irq_ctl", ctl(), 16'b111010);
    $display("step irq entry: new_pc=%h ctl=%b", new_pc, ctl());
    adv();
    chk("irq_epc", epc, 16'h0033);
    pc_cur = 16'h0010;
    settle();
    chk("irq_hold_ctl", ctl(), 16'b110000);
    chk("irq_hold_newpc", new_pc, 16'h0011);
    $display("step irq held: new_pc=%h ctl=%b", new_pc, ctl());
    adv();
    pc_cur = 16'h0011; iret = 1'b1;
    settle();
    chk("iret_newpc", new_pc, 16'h0033);
    chk("iret_ctl", ctl(), 16'b111000);
    $display("step iret: new_pc=%h ctl=%b", new_pc, ctl());
    adv();
    iret = 1'b0; pc_cur = 16'h0034;
    settle();
    chk("retake_ctl", ctl(), 16'b111010);
    chk("retake_newpc", new_pc, 16'h0010);
    $display("step irq retaken: new_pc=%h ctl=%b", new_pc, ctl());
    adv();
    chk("retake_epc", epc, 16'h0034);
    irq = 1'b0; pc_cur = 16'h0012; iret = 1'b1;
    settle();
    chk("iret2_newpc", new_pc, 16'h0034);
    adv();
    iret = 1'b0; pc_cur = 16'h0035; jmp = 1'b1; jmp_target = 16'h0060; irq = 1'b1;
    settle();
    chk("jmp_irq_newpc", new_pc, 16'h0060);
    chk("jmp_irq_ctl", ctl(), 16'b111000);
    $display("step jmp+irq: new_pc=%h ctl=%b", new_pc, ctl());
    adv();
    jmp = 1'b0; pc_cur = 16'h0060;
    settle();
    chk("irq_after_jmp_ctl", ctl(), 16'b111010);
    chk("irq_after_jmp_newpc", new_pc, 16'h0010);
    adv();
    chk("irq_after_jmp_epc", epc, 16'h0060);
    irq = 1'b0; pc_cur = 16'h0010; iret = 1'b1;
    settle();
    chk("iret3_newpc", new_pc, 16'h0060);
    adv();
    iret = 1'b0;

    // ---- Halt and wake ----
    pc_cur = 16'h0050; halt_req = 1'b1;
    settle();
    chk("halt_req_ctl", ctl(), 16'b011000);
    $display("step halt request: ctl=%b", ctl());
    adv();
    halt_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      settle();
      chk("halted_ctl", ctl(), 16'b000001);
      $display("step halted cycle %0d: ctl=%b", i, ctl());
      adv();
    end
    irq = 1'b1;
    settle();
    chk("wake_newpc", new_pc, 16'h0010);
    chk("wake_ctl", ctl(), 16'b100011);
    $display("step wake: new_pc=%h ctl=%b", new_pc, ctl());
    adv();
    chk("wake_epc", epc, 16'h0050);
    irq = 1'b0; pc_cur = 16'h0010;
    settle();
    chk("woken_ctl", ctl(), 16'b110000);
    adv();

    // Halt inside the handler: irq cannot wake it.
    pc_cur = 16'h0011; halt_req = 1'b1;
    adv();
    halt_req = 1'b0; irq = 1'b1;
    for (int i = 0; i < 5; i++) begin
      settle();
      chk("halt_noirq_ctl", ctl(), 16'b000001);
      $display("step halted irq disabled %0d: ctl=%b", i, ctl());
      adv();
    end
    irq = 1'b0; reset = 1'b0;
    adv();
    reset = 1'b1;
    settle();
    chk("post_halt_rst_ctl", ctl(), 16'b110000);
    chk("post_halt_rst_epc", epc, 16'h0000);
    $display("step reset out of halt: ctl=%b epc=%h", ctl(), epc);
    adv();

    // ---- Reset mid-PEND ----
    pc_cur = 16'h0100; jmp = 1'b1; jmp_target = 16'h0200; imem_ready = 1'b0;
    adv();
    jmp = 1'b0;
    settle();
    chk("pend_again_ctl", ctl(), 16'b011000);
    reset = 1'b0;
    adv();
    reset = 1'b1; imem_ready = 1'b1; pc_cur = 16'h0101;
    settle();
    chk("rst_pend_newpc", new_pc, 16'h0102);
    chk("rst_pend_ctl", ctl(), 16'b110000);
    $display("step reset mid-pend: new_pc=%h ctl=%b", new_pc, ctl());
    adv();

    // irq_en restored by reset.
    irq = 1'b1;
    settle();
    chk("rst_irq_en_ctl", ctl(), 16'b111010);
    $display("step irq after reset: ctl=%b", ctl());
    adv();
    irq = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
